acc_op_sequencer: RTL and testbench

//  Upstream feeder of the acc accumulator. Accepts a framed operand stream (valid/ready, sof/eof),

---
 rtl/acc_pkg.sv | 17 +
 rtl/acc_op_sequencer_if.sv | 33 +++
 rtl/acc_seq_fifo.sv | 46 ++++
 rtl/acc_op_sequencer.sv | 124 ++++++++++++
 tb/tb_acc_op_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared types for the acc operand sequencer: datapath width, FSM states and FIFO word layout.
package acc_pkg;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic                  sof;
    logic                  eof;
    logic [DATA_WIDTH-1:0] data;
  } seq_word_t;
endpackage

// File: rtl/acc_op_sequencer_if.sv
// Operand stream, acc control and frame-sum result signals of the acc operand sequencer.
interface acc_op_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_sof;
  logic                  in_eof;
  logic [DATA_WIDTH-1:0] bias;
  logic [DATA_WIDTH-1:0] acc_a;
  logic [DATA_WIDTH-1:0] acc_b;
  logic                  acc_accumulate;
  logic                  acc_en_n;
  logic [DATA_WIDTH-1:0] acc_y;
  logic                  sum_valid;
  logic                  sum_ready;
  logic [DATA_WIDTH-1:0] sum_data;
  logic [15:0]           sum_len;
  logic                  frame_err;

  modport master (
    output in_valid, in_data, in_sof, in_eof, bias, acc_y, sum_ready,
    input  in_ready, acc_a, acc_b, acc_accumulate, acc_en_n, sum_valid, sum_data, sum_len,
           frame_err
  );

  modport slave (
    input  in_valid, in_data, in_sof, in_eof, bias, acc_y, sum_ready,
    output in_ready, acc_a, acc_b, acc_accumulate, acc_en_n, sum_valid, sum_data, sum_len,
           frame_err
  );
endinterface

// File: rtl/acc_seq_fifo.sv
// Synchronous FIFO of framed operand words; pointers carry one wrap bit to tell full from empty.
module acc_seq_fifo
  import acc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  seq_word_t wdata_i,
  input  logic      pop_i,
  output seq_word_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  seq_word_t     mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i && !full_o) wptr_d = wptr_q + 1'b1;
    if (pop_i && !empty_o) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/acc_op_sequencer.sv
// Feeds buffered operand frames into the external acc accumulator and returns one sum per frame.
module acc_op_sequencer
  import acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = acc_pkg::DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  acc_op_sequencer_if.slave bus
);
  seq_state_t            state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  accm_q, accm_d;
  logic                  en_n_q, en_n_d;
  logic                  err_q, err_d;
  logic                  sv_q, sv_d;
  logic [DATA_WIDTH-1:0] sd_q, sd_d;

  seq_word_t head;
  seq_word_t wword;
  logic      full, empty, pop;

  assign wword.sof  = bus.in_sof;
  assign wword.eof  = bus.in_eof;
  assign wword.data = bus.in_data;

  assign bus.in_ready = !full && !rst;
  assign pop = ((state_q == IDLE) || (state_q == RUN)) && !empty;

  acc_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid && bus.in_ready),
    .wdata_i (wword),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    a_d     = a_q;
    b_d     = b_q;
    accm_d  = accm_q;
    en_n_d  = 1'b1;
    err_d   = 1'b0;
    sv_d    = sv_q;
    sd_d    = sd_q;
    case (state_q)
      IDLE, RUN: begin
        if (pop) begin
          if (head.sof) begin
            // A sof seen mid-frame restarts the frame; the partial sum is simply overwritten.
            a_d     = head.data;
            b_d     = bus.bias;
            accm_d  = 1'b0;
            en_n_d  = 1'b0;
            len_d   = 16'd1;
            err_d   = (state_q == RUN);
            state_d = head.eof ? WAIT : RUN;
          end else if (state_q == RUN) begin
            a_d     = head.data;
            accm_d  = 1'b1;
            en_n_d  = 1'b0;
            len_d   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
            state_d = head.eof ? WAIT : RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT: state_d = DONE;
      DONE: begin
        // First DONE cycle captures acc_y (settled since WAIT); handshake follows.
        if (!sv_q) begin
          sv_d = 1'b1;
          sd_d = bus.acc_y;
        end else if (bus.sum_ready) begin
          sv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      accm_q  <= 1'b0;
      en_n_q  <= 1'b1;
      err_q   <= 1'b0;
      sv_q    <= 1'b0;
      sd_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      a_q     <= a_d;
      b_q     <= b_d;
      accm_q  <= accm_d;
      en_n_q  <= en_n_d;
      err_q   <= err_d;
      sv_q    <= sv_d;
      sd_q    <= sd_d;
    end
  end

  assign bus.acc_a          = a_q;
  assign bus.acc_b          = b_q;
  assign bus.acc_accumulate = accm_q;
  assign bus.acc_en_n       = en_n_q;
  assign bus.sum_valid      = sv_q;
  assign bus.sum_data       = sd_q;
  assign bus.sum_len        = len_q;
  assign bus.frame_err      = err_q;
endmodule

// File: tb/tb_acc_op_sequencer.sv
// Randomised and directed bench for acc_op_sequencer with a frame-level sum model and an acc model.
module tb_acc_op_sequencer;
  import acc_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_op_sequencer_if #(.DATA_WIDTH(W)) ifc ();

  acc_op_sequencer #(.DATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // External accumulator behaviour (not reset, as in the real system)
  logic [W-1:0] y_q = '0;
  always @(posedge clk)
    if (!ifc.acc_en_n) y_q <= ifc.acc_a + (ifc.acc_accumulate ? y_q : ifc.acc_b);
  assign ifc.acc_y = y_q;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame-level model: words are processed in arrival order
  logic [W-1:0] exp_sum_q[$];
  int           exp_len_q[$];
  logic [W-1:0] got_sum_q[$];
  bit           m_in = 0;
  logic [W-1:0] m_sum;
  int           m_len;
  int exp_err = 0, exp_en = 0, obs_err = 0, obs_en = 0;
  int sum_cnt = 0, sv_cycles = 0, last_len = 0;
  logic [W-1:0] last_sum = '0;
  bit saw_full = 0;

  task automatic model_accept(input logic [W-1:0] d, input logic s, input logic e);
    if (s) begin
      if (m_in) exp_err++;
      m_in = 1; m_sum = d + ifc.bias; m_len = 1; exp_en++;
    end else if (m_in) begin
      m_sum = m_sum + d; m_len = (m_len == 65535) ? m_len : m_len + 1; exp_en++;
    end else begin
      exp_err++;
    end
    if (m_in && e) begin
      exp_sum_q.push_back(m_sum);
      exp_len_q.push_back(m_len);
      m_in = 0;
    end
  endtask

  task automatic model_reset();
    exp_sum_q.delete();
    exp_len_q.delete();
    m_in = 0;
  endtask

  // sum_ready driver
  bit sr_rand = 0;
  bit sr_val  = 0;
  always @(negedge clk) ifc.sum_ready = sr_rand ? 1'($urandom_range(0, 1)) : sr_val;

  // Compare process: sampled just before each rising edge
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      if (ifc.frame_err) obs_err++;
      if (!ifc.acc_en_n) obs_en++;
      if (ifc.sum_valid) sv_cycles++;
      if (ifc.in_valid && !ifc.in_ready) saw_full = 1;
      if (ifc.sum_valid && ifc.sum_ready) begin
        if (exp_sum_q.size() == 0) begin
          check("spurious_sum", {32'd0, ifc.sum_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("sum_data", {32'd0, ifc.sum_data}, {32'd0, exp_sum_q.pop_front()});
          check("sum_len", {48'd0, ifc.sum_len}, 64'(exp_len_q.pop_front()));
        end
        last_sum = ifc.sum_data;
        last_len = int'(ifc.sum_len);
        got_sum_q.push_back(ifc.sum_data);
        sum_cnt++;
      end
    end
  end

  task automatic push(input logic [W-1:0] d, input logic s, input logic e);
    bit acc = 0;
    @(negedge clk);
    ifc.in_valid = 1'b1; ifc.in_data = d; ifc.in_sof = s; ifc.in_eof = e;
    for (int k = 0; k < 400; k++) begin
      #4;
      acc = ifc.in_ready;
      @(posedge clk);
      if (acc) break;
      #5;
    end
    if (acc) model_accept(d, s, e);
    else check("push_timeout", 64'd0, 64'd1);
    #1 ifc.in_valid = 1'b0;
  endtask

  task automatic wait_sums(input int target);
    for (int k = 0; k < 600 && sum_cnt < target; k++) @(negedge clk);
    check("sum_wait", 64'(sum_cnt >= target), 64'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 2000 && exp_sum_q.size() != 0; k++) @(negedge clk);
    check("drain_wait", 64'(exp_sum_q.size()), 64'd0);
    repeat (6) @(negedge clk);
  endtask

  int e_err0, e_en0, o_err0, o_en0, sc0, sv0;
  task automatic phase_begin();
    e_err0 = exp_err; e_en0 = exp_en; o_err0 = obs_err; o_en0 = obs_en;
    sc0 = sum_cnt; sv0 = sv_cycles;
  endtask
  task automatic phase_end(input string name);
    check({name, "_err"}, 64'(obs_err - o_err0), 64'(exp_err - e_err0));
    check({name, "_en"},  64'(obs_en - o_en0),  64'(exp_en - e_en0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(ifc.in_ready), 64'd0);
    check({tag, "_acc_a"},     64'(ifc.acc_a), 64'd0);
    check({tag, "_acc_b"},     64'(ifc.acc_b), 64'd0);
    check({tag, "_accum"},     64'(ifc.acc_accumulate), 64'd0);
    check({tag, "_en_n"},      64'(ifc.acc_en_n), 64'd1);
    check({tag, "_sum_valid"}, 64'(ifc.sum_valid), 64'd0);
    check({tag, "_sum_data"},  64'(ifc.sum_data), 64'd0);
    check({tag, "_sum_len"},   64'(ifc.sum_len), 64'd0);
    check({tag, "_frame_err"}, 64'(ifc.frame_err), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_sof = 1'b0; ifc.in_eof = 1'b0;
    ifc.bias = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #4;
    check_reset_outputs("rst");
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #4;
    check("in_ready_after_rst", 64'(ifc.in_ready), 64'd1);

    // Simple frame 1,2,3
    sr_val = 1;
    phase_begin();
    push(32'd1, 1, 0); push(32'd2, 0, 0); push(32'd3, 0, 1);
    wait_sums(sc0 + 1);
    check("f123_sum", 64'(last_sum), 64'd6);
    check("f123_len", 64'(last_len), 64'd3);
    wait_drain();
    check("f123_valid_cycles", 64'(sv_cycles - sv0), 64'd1);
    phase_end("f123");

    // Single-word wrap with bias 2
    ifc.bias = 32'd2;
    phase_begin();
    push(32'hFFFF_FFFF, 1, 1);
    wait_sums(sc0 + 1);
    check("wrap_sum", 64'(last_sum), 64'd1);
    check("wrap_len", 64'(last_len), 64'd1);
    wait_drain();
    phase_end("wrap");

    // Back-pressure: 5 frames of 4 words while sum_ready held low
    ifc.bias = '0;
    sr_val = 0; saw_full = 0;
    got_sum_q.delete();
    phase_begin();
    fork
      for (int i = 1; i <= 20; i++) push(32'(i), (i % 4) == 1, (i % 4) == 0);
      begin repeat (20) @(negedge clk); sr_val = 1; end
    join
    wait_drain();
    check("bp_saw_full", 64'(saw_full), 64'd1);
    check("bp_count", 64'(got_sum_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < got_sum_q.size(); i++)
      check("bp_sum", 64'(got_sum_q[i]), 64'(10 + 16 * i));
    phase_end("bp");

    // Frame restart
    phase_begin();
    push(32'd5, 1, 0); push(32'd7, 0, 0); push(32'd9, 1, 0); push(32'd1, 0, 1);
    wait_sums(sc0 + 1);
    wait_drain();
    check("restart_err", 64'(obs_err - o_err0), 64'd1);
    check("restart_sum", 64'(last_sum), 64'd10);
    check("restart_len", 64'(last_len), 64'd2);
    phase_end("restart");

    // Stray non-sof word in IDLE
    phase_begin();
    push(32'h55, 0, 0);
    repeat (8) @(negedge clk);
    check("stray_err", 64'(obs_err - o_err0), 64'd1);
    check("stray_en", 64'(obs_en - o_en0), 64'd0);
    check("stray_nosum", 64'(sum_cnt - sc0), 64'd0);

    // Reset mid-frame
    push(32'd7, 1, 0); push(32'd8, 0, 0); push(32'd9, 0, 0);
    @(negedge clk); rst = 1'b1; model_reset();
    @(negedge clk); #4;
    check_reset_outputs("midrst");
    @(negedge clk); rst = 1'b0;
    phase_begin();
    push(32'd4, 1, 0); push(32'd4, 0, 1);
    wait_sums(sc0 + 1);
    check("post_rst_sum", 64'(last_sum), 64'd8);
    check("post_rst_len", 64'(last_len), 64'd2);
    wait_drain();
    phase_end("post_rst");

    // Randomised traffic
    sr_rand = 1;
    ifc.bias = $urandom;
    phase_begin();
    for (int i = 0; i < 400; i++) begin
      logic s, e;
      s = m_in ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 9) != 0);
      e = ($urandom_range(0, 3) == 0);
      push($urandom, s, e);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    if (m_in) push($urandom, 0, 1);
    wait_drain();
    phase_end("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
